// File: rtl/fetch_sequencer_pkg.sv
// Shared widths, constants and state encoding for the fetch sequencer.
package fetch_sequencer_pkg;

    localparam int          ADRS_W     = 7;
    localparam int          INSTR_W    = 32;
    localparam logic [6:0]  PC_STEP    = 7'd4;
    localparam logic [31:0] ZERO_INSTR = 32'h0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HALT  = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/fetch_sequencer_out_reg.sv
// One-entry valid/ready holding register for the fetched word and its address.
// flush drops the entry (a same-edge handshake still counts as taken);
// load overwrites it and wins over a plain drain.
module fetch_out_reg
    import fetch_sequencer_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               flush,
    input  logic               load,
    input  logic               ready,
    input  logic [INSTR_W-1:0] in_instr,
    input  logic [ADRS_W-1:0]  in_pc,
    output logic               valid,
    output logic [INSTR_W-1:0] instr,
    output logic [ADRS_W-1:0]  pc
);

    // Valid bit: flush clears, load sets, an accepted beat with no refill clears.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= 1'b0;
        end else if (flush) begin
            valid <= 1'b0;
        end else if (load) begin
            valid <= 1'b1;
        end else if (valid && ready) begin
            valid <= 1'b0;
        end
    end

    // Payload only changes on a load; it holds across flush and drain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr <= ZERO_INSTR;
            pc    <= '0;
        end else if (load && !flush) begin
            instr <= in_instr;
            pc    <= in_pc;
        end
    end

endmodule

// File: rtl/fetch_sequencer.sv
// PC sequencer and fetch controller for the 32x32 instruction ROM.
// Drives the byte address and active-low chip select, captures words into a
// one-entry output register, follows redirects, halts on a zero word and
// traps misaligned redirect targets.
module fetch_sequencer
    import fetch_sequencer_pkg::*;
#(
    parameter logic [6:0] START_ADRS   = 7'h00,
    parameter bit         HALT_ON_ZERO = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        redirect,
    input  logic [6:0]  redirect_adrs,
    input  logic [31:0] rom_data,
    output logic [6:0]  rom_adrs,
    output logic        rom_cs,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [6:0]  out_pc,
    output logic        busy,
    output logic        halted,
    output logic        fault
);

    fetch_state_e       state, state_nxt;
    logic [ADRS_W-1:0]  pc, pc_nxt;
    logic               halted_nxt, fault_nxt;
    logic               flush, load;
    logic               slot_free, zero_word;

    assign slot_free = !out_valid || out_ready;
    assign zero_word = HALT_ON_ZERO && (rom_data == ZERO_INSTR);

    // State, PC and sticky flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            pc     <= START_ADRS;
            halted <= 1'b0;
            fault  <= 1'b0;
        end else begin
            state  <= state_nxt;
            pc     <= pc_nxt;
            halted <= halted_nxt;
            fault  <= fault_nxt;
        end
    end

    // Next state: start beats everything, then redirect, then capture/halt.
    always_comb begin
        state_nxt  = state;
        pc_nxt     = pc;
        halted_nxt = halted;
        fault_nxt  = fault;
        flush      = 1'b0;
        load       = 1'b0;
        if (start) begin
            state_nxt  = FETCH;
            pc_nxt     = START_ADRS;
            halted_nxt = 1'b0;
            fault_nxt  = 1'b0;
            flush      = 1'b1;
        end else begin
            case (state)
                FETCH: begin
                    if (redirect) begin
                        // Current ROM word is dropped; pending beat is lost unless taken now.
                        flush = 1'b1;
                        if (|redirect_adrs[1:0]) begin
                            fault_nxt  = 1'b1;
                            halted_nxt = 1'b1;
                            state_nxt  = HALT;
                        end else begin
                            pc_nxt = redirect_adrs;
                        end
                    end else if (slot_free) begin
                        if (zero_word) begin
                            // Not captured; a same-edge handshake drains normally.
                            halted_nxt = 1'b1;
                            state_nxt  = HALT;
                        end else begin
                            load   = 1'b1;
                            pc_nxt = pc + PC_STEP;
                        end
                    end
                end
                IDLE, HALT: ;
                default: state_nxt = IDLE;
            endcase
        end
    end

    assign rom_adrs = pc;
    assign rom_cs   = (state != FETCH);
    assign busy     = (state == FETCH);

    fetch_out_reg u_out (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush    (flush),
        .load     (load),
        .ready    (out_ready),
        .in_instr (rom_data),
        .in_pc    (pc),
        .valid    (out_valid),
        .instr    (out_instr),
        .pc       (out_pc)
    );

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench: directed scenarios plus a random phase, all compared
// against a cycle-by-cycle behavioural model of the fetch rules.
module tb_fetch_sequencer;

    localparam int S_IDLE = 0, S_FETCH = 1, S_HALT = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        start0, redirect0, out_ready0;
    logic [6:0]  radrs0;
    logic [31:0] rom_data0, out_instr0;
    logic [6:0]  rom_adrs0, out_pc0;
    logic        rom_cs0, out_valid0, busy0, halted0, fault0;

    logic        start1, out_ready1;
    logic [31:0] rom_data1, out_instr1;
    logic [6:0]  rom_adrs1, out_pc1;
    logic        rom_cs1, out_valid1, busy1, halted1, fault1;

    logic [31:0] rom [32];
    assign rom_data0 = rom[rom_adrs0[6:2]];
    assign rom_data1 = rom[rom_adrs1[6:2]];

    fetch_sequencer dut0 (
        .clk(clk), .rst_n(rst_n), .start(start0), .redirect(redirect0),
        .redirect_adrs(radrs0), .rom_data(rom_data0), .rom_adrs(rom_adrs0),
        .rom_cs(rom_cs0), .out_valid(out_valid0), .out_ready(out_ready0),
        .out_instr(out_instr0), .out_pc(out_pc0), .busy(busy0),
        .halted(halted0), .fault(fault0)
    );

    fetch_sequencer #(.START_ADRS(7'h7C), .HALT_ON_ZERO(1'b0)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .redirect(1'b0),
        .redirect_adrs(7'h00), .rom_data(rom_data1), .rom_adrs(rom_adrs1),
        .rom_cs(rom_cs1), .out_valid(out_valid1), .out_ready(out_ready1),
        .out_instr(out_instr1), .out_pc(out_pc1), .busy(busy1),
        .halted(halted1), .fault(fault1)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // model of dut0 (START_ADRS=0, HALT_ON_ZERO=1)
    int          m_st;
    logic [6:0]  m_pc, m_opc;
    logic        m_v, m_halt, m_fault;
    logic [31:0] m_instr;

    logic        snap_v;
    logic [38:0] snap;
    logic [38:0] beats[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_st = S_IDLE; m_pc = 7'h00; m_opc = 7'h00; m_v = 1'b0;
        m_halt = 1'b0; m_fault = 1'b0; m_instr = 32'h0;
    endtask

    task automatic model_update();
        logic        xfer;
        logic [31:0] w;
        xfer = m_v && out_ready0;
        w    = rom[m_pc[6:2]];
        if (start0) begin
            m_st = S_FETCH; m_pc = 7'h00; m_v = 1'b0; m_halt = 1'b0; m_fault = 1'b0;
        end else if (m_st == S_FETCH && redirect0) begin
            m_v = 1'b0;
            if (radrs0[1:0] != 2'b00) begin
                m_fault = 1'b1; m_halt = 1'b1; m_st = S_HALT;
            end else begin
                m_pc = radrs0;
            end
        end else if (m_st == S_FETCH && (!m_v || out_ready0)) begin
            if (w == 32'h0) begin
                m_halt = 1'b1; m_st = S_HALT; m_v = m_v && !xfer;
            end else begin
                m_v = 1'b1; m_instr = w; m_opc = m_pc; m_pc = 7'((int'(m_pc) + 4) % 128);
            end
        end else if (xfer) begin
            m_v = 1'b0;
        end
    endtask

    task automatic check_model();
        chk("out_valid", 32'(out_valid0), 32'(m_v));
        chk("out_instr", out_instr0, m_instr);
        chk("out_pc", 32'(out_pc0), 32'(m_opc));
        chk("rom_adrs", 32'(rom_adrs0), 32'(m_pc));
        chk("rom_cs", 32'(rom_cs0), 32'(m_st != S_FETCH));
        chk("busy", 32'(busy0), 32'(m_st == S_FETCH));
        chk("halted", 32'(halted0), 32'(m_halt));
        chk("fault", 32'(fault0), 32'(m_fault));
    endtask

    // One clock: record a transferring beat, advance the model, check after the edge.
    task automatic step();
        @(posedge clk);
        if (snap_v && out_ready0) beats.push_back(snap);
        model_update();
        #1;
        check_model();
        snap_v = out_valid0;
        snap   = {out_pc0, out_instr0};
    endtask

    initial begin
        logic [31:0] r;
        rom = '{32'h00450693, 32'h00100713, 32'h00b76463, 32'h00008067,
                32'h0006a803, 32'h00068613, 32'h00070793, 32'hffc62883,
                32'h01185a63, 32'h01162023, 32'h01062223, 32'hffc60613,
                32'hfee794e3, 32'h00178793, 32'h00470713, 32'hfd1ff06f,
                32'h00d62023, 32'h00e6a023, 32'hfc1ff06f, 32'h0,
                32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0,
                32'h0, 32'h0, 32'h0, 32'h0};
        rst_n = 1'b0; start0 = 0; redirect0 = 0; radrs0 = 0; out_ready0 = 0;
        start1 = 0; out_ready1 = 0; snap_v = 0; snap = '0;
        model_reset();
        #12;
        check_model();
        chk("rst_cs1", 32'(rom_cs1), 32'h1);
        @(negedge clk) rst_n = 1'b1;
        step();

        // full program run to the zero word
        beats.delete();
        start0 = 1; out_ready0 = 1; step(); start0 = 0;
        for (int i = 0; i < 40 && !halted0; i++) step();
        chk("run_beats", beats.size(), 19);
        if (beats.size() == 19) begin
            chk("run_b0", 32'(beats[0]), 32'h00450693);
            chk("run_b0pc", 32'(beats[0][38:32]), 32'h00);
            chk("run_b1", 32'(beats[1]), 32'h00100713);
            chk("run_b18", 32'(beats[18]), 32'hfc1ff06f);
            chk("run_b18pc", 32'(beats[18][38:32]), 32'h48);
        end
        chk("run_halted", 32'(halted0), 32'h1);
        chk("run_cs", 32'(rom_cs0), 32'h1);

        // backpressure after the first beat
        start0 = 1; step(); start0 = 0; step();
        beats.delete();
        out_ready0 = 0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("bp_instr", out_instr0, 32'h00450693);
            chk("bp_pc", 32'(out_pc0), 32'h00);
            chk("bp_adrs", 32'(rom_adrs0), 32'h04);
        end
        out_ready0 = 1; step();
        chk("bp_next", out_instr0, 32'h00100713);
        step();
        chk("bp_nbeats", beats.size(), 2);
        if (beats.size() == 2) begin
            chk("bp_b0pc", 32'(beats[0][38:32]), 32'h00);
            chk("bp_b1pc", 32'(beats[1][38:32]), 32'h04);
        end

        // aligned redirect at pc 0x08
        start0 = 1; step(); start0 = 0;
        for (int i = 0; i < 10 && rom_adrs0 != 7'h08; i++) step();
        chk("rd_at8", 32'(rom_adrs0), 32'h08);
        beats.delete();
        redirect0 = 1; radrs0 = 7'h20; step(); redirect0 = 0;
        chk("rd_flush", 32'(out_valid0), 32'h0);
        step();
        chk("rd_pc20", 32'(out_pc0), 32'h20);
        chk("rd_i20", out_instr0, 32'h01185a63);
        step();
        chk("rd_pc24", 32'(out_pc0), 32'h24);
        chk("rd_i24", out_instr0, 32'h01162023);
        step();
        foreach (beats[i]) chk("rd_no08", 32'(beats[i][38:32] == 7'h08), 32'h0);

        // misaligned redirect
        redirect0 = 1; radrs0 = 7'h22; step(); redirect0 = 0;
        chk("mis_fault", 32'(fault0), 32'h1);
        chk("mis_halted", 32'(halted0), 32'h1);
        beats.delete();
        for (int i = 0; i < 3; i++) step();
        chk("mis_nobeats", beats.size(), 0);
        start0 = 1; step(); start0 = 0;
        chk("mis_clr_f", 32'(fault0), 32'h0);
        chk("mis_clr_h", 32'(halted0), 32'h0);
        step();
        chk("mis_resume", 32'(out_pc0), 32'h00);

        // wrap instance: START_ADRS=0x7C, zero word issued
        start1 = 1; out_ready1 = 1; step(); start1 = 0;
        chk("wr_busy", 32'(busy1), 32'h1);
        chk("wr_cs", 32'(rom_cs1), 32'h0);
        step();
        chk("wr_v0", 32'(out_valid1), 32'h1);
        chk("wr_pc0", 32'(out_pc1), 32'h7C);
        chk("wr_i0", out_instr1, 32'h0);
        step();
        chk("wr_pc1", 32'(out_pc1), 32'h00);
        chk("wr_i1", out_instr1, 32'h00450693);
        chk("wr_noflag", 32'({halted1, fault1}), 32'h0);

        // random traffic
        for (int i = 0; i < 400; i++) begin
            r = $urandom;
            start0     = (m_st == S_FETCH) ? ($urandom_range(0, 39) == 0) : ($urandom_range(0, 3) == 0);
            redirect0  = ($urandom_range(0, 9) == 0);
            radrs0     = r[6:0];
            if ($urandom_range(0, 3) != 0) radrs0[1:0] = 2'b00;
            out_ready0 = ($urandom_range(0, 9) < 7);
            step();
        end
        start0 = 0; redirect0 = 0;

        // async reset with a pending word
        out_ready0 = 0; start0 = 1; step(); start0 = 0; step();
        chk("ar_pending", 32'(out_valid0), 32'h1);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check_model();
        chk("ar_v1", 32'(out_valid1), 32'h0);
        @(negedge clk) rst_n = 1'b1;
        snap_v = 0;
        for (int i = 0; i < 3; i++) step();
        chk("ar_idle", 32'(busy0), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
